// File: rtl/dpu_csr_apb_initiator.sv
// ============================================================================
// Module   : dpu_csr_apb_initiator
// Purpose  : Command/response to single APB3 transfer initiator for the DPU
//            CSR bus. Optional ACCESS-phase timeout under APB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpu_csr_apb_initiator #(
    parameter int APB_WIDTH_AD = 32,
    parameter int APB_WIDTH_DA = 32,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic                    PRESETn,
    input  logic                    PCLK,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [APB_WIDTH_AD-1:0] cmd_addr,
    input  logic [APB_WIDTH_DA-1:0] cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [APB_WIDTH_DA-1:0] rsp_rdata,
    output logic                    rsp_error,
    output logic                    busy,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic [APB_WIDTH_AD-1:0] PADDR,
    output logic                    PWRITE,
    output logic [APB_WIDTH_DA-1:0] PWDATA,
    input  logic [APB_WIDTH_DA-1:0] PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic [APB_WIDTH_AD-1:0] paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [APB_WIDTH_DA-1:0] pwdata_q, pwdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [APB_WIDTH_DA-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_error_q, rsp_error_d;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned           c_CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0]    c_LIMIT = c_CNT_W'(TIMEOUT_CYC);
    logic [c_CNT_W-1:0]               cnt_q, cnt_d;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= S_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
`ifdef APB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    // Reads drive zero on PWDATA rather than stale data
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            S_ACCESS: begin
                if (PREADY) begin
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_error_d = PSLVERR;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
`ifdef APB_TIMEOUT_EN
                // A responder that never answers is abandoned with an error
                else if (cnt_q == c_LIMIT) begin
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

`default_nettype wire

// File: tb/tb_dpu_csr_apb_initiator.sv
// ============================================================================
// Module   : tb_dpu_csr_apb_initiator
// Purpose  : Self-checking bench for dpu_csr_apb_initiator; transfer timing
//            expectations come from a cycle-count model of the APB phases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dpu_csr_apb_initiator;

    localparam int TMO = 4;

    logic        PRESETn = 1'b0;
    logic        PCLK    = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, rsp_error, busy;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0, PSLVERR = 1'b0;

    int checks = 0;
    int errors = 0;

    // Observations gathered by do_xfer, judged by the scenario tasks
    int          ob_psel_n, ob_pen_n, ob_psel_first, ob_pen_first;
    int          ob_rv_first, ob_rv_n, ob_ret, ob_viol;
    logic [31:0] ob_rdata;
    logic        ob_err;

    always #5 PCLK = ~PCLK;

    dpu_csr_apb_initiator #(
        .APB_WIDTH_AD(32), .APB_WIDTH_DA(32), .TIMEOUT_CYC(TMO)
    ) dut (
        .PRESETn(PRESETn), .PCLK(PCLK),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // Issue one command from idle and act as responder/consumer; with hold=1
    // a second command is presented immediately and must wait for the handshake.
    task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int waits, input int rdly, input logic [31:0] prd,
                           input logic err, input logic hold);
        int acc = 0;
        int rv  = 0;
        ob_psel_n = 0; ob_pen_n = 0; ob_psel_first = -1; ob_pen_first = -1;
        ob_rv_first = -1; ob_rv_n = 0; ob_ret = -1; ob_viol = 0;
        ob_rdata = 'x; ob_err = 1'bx;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge PCLK); #1;
            if (cyc == 1) begin
                if (hold) begin
                    cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~d;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (cmd_ready === busy) ob_viol++;
            if (PENABLE && !PSEL) ob_viol++;
            if (PADDR !== a) ob_viol++;
            if (PSEL && (PWRITE !== w || PWDATA !== (w ? d : 32'h0))) ob_viol++;
            if (PSEL) begin
                ob_psel_n++;
                if (ob_psel_first < 0) ob_psel_first = cyc;
            end
            if (PENABLE) begin
                ob_pen_n++;
                if (ob_pen_first < 0) ob_pen_first = cyc;
            end
            if (cmd_ready) begin
                ob_ret = cyc;
                break;
            end
            if (PSEL && PENABLE) begin
                PREADY  = (acc >= waits);
                PRDATA  = PREADY ? prd : $urandom;
                PSLVERR = PREADY ? err : 1'($urandom);
                acc++;
            end else begin
                PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
            end
            if (rsp_valid) begin
                if (rv == 0) begin
                    ob_rv_first = cyc; ob_rdata = rsp_rdata; ob_err = rsp_error;
                end else if (rsp_rdata !== ob_rdata || rsp_error !== ob_err) begin
                    ob_viol++;
                end
                ob_rv_n++;
                rsp_ready = (rv >= rdly);
                rv++;
            end else begin
                rsp_ready = 1'($urandom);
            end
        end
        PREADY = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        checks++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 00000", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_error});
        end
        checks++;
        if (PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h exp 0/0/0", PADDR, PWDATA, rsp_rdata);
        end
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b busy=%b exp rdy=1 busy=0", cmd_ready, busy);
        end
    endtask

    task automatic test_read_basic();
        do_xfer(1'b0, 32'h0, 32'h0, 0, 0, 32'h2021_0610, 1'b0, 1'b0);
        checks++;
        if (ob_psel_first !== 1 || ob_psel_n !== 2) begin
            errors++;
            $display("FAIL rd_psel got first=%0d n=%0d exp first=1 n=2", ob_psel_first, ob_psel_n);
        end
        checks++;
        if (ob_pen_first !== 2 || ob_pen_n !== 1) begin
            errors++;
            $display("FAIL rd_penable got first=%0d n=%0d exp first=2 n=1", ob_pen_first, ob_pen_n);
        end
        checks++;
        if (ob_rv_first !== 3 || ob_ret !== 4) begin
            errors++;
            $display("FAIL rd_latency got rv=%0d ret=%0d exp rv=3 ret=4", ob_rv_first, ob_ret);
        end
        checks++;
        if (ob_rdata !== 32'h2021_0610 || ob_err !== 1'b0 || ob_viol !== 0) begin
            errors++;
            $display("FAIL rd_data got %h err=%b viol=%0d exp 20210610 err=0 viol=0", ob_rdata, ob_err, ob_viol);
        end
    endtask

    task automatic test_read_regs();
        logic [31:0] addrs [2] = '{32'h10, 32'h24};
        logic [31:0] vals  [2] = '{32'h0020_0020, 32'h0};
        for (int i = 0; i < 2; i++) begin
            do_xfer(1'b0, addrs[i], $urandom, 0, 0, vals[i], 1'b0, 1'b0);
            checks++;
            if (ob_rdata !== vals[i] || ob_ret !== 4 || ob_viol !== 0) begin
                errors++;
                $display("FAIL rd_reg%0d got %h ret=%0d viol=%0d exp %h ret=4 viol=0", i, ob_rdata, ob_ret, ob_viol, vals[i]);
            end
        end
    endtask

    task automatic test_write_waits();
        do_xfer(1'b1, 32'h44, 32'hDEAD_BEEF, 3, 0, $urandom, 1'b0, 1'b0);
        checks++;
        if (ob_pen_n !== 4 || ob_psel_n !== 5 || ob_viol !== 0) begin
            errors++;
            $display("FAIL wr_access got pen=%0d psel=%0d viol=%0d exp 4/5/0", ob_pen_n, ob_psel_n, ob_viol);
        end
        checks++;
        if (ob_rv_first !== 6 || ob_rdata !== 32'h0 || ob_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp got rv=%0d data=%h err=%b exp rv=6 data=0 err=0", ob_rv_first, ob_rdata, ob_err);
        end
    endtask

    task automatic test_error_back_to_back();
        logic [31:0] a = $urandom;
        logic [31:0] prd = $urandom;
        do_xfer(1'b0, a, 32'h0, 0, 5, prd, 1'b1, 1'b1);
        checks++;
        if (ob_err !== 1'b1 || ob_rdata !== prd || ob_rv_n !== 6 || ob_ret !== 9) begin
            errors++;
            $display("FAIL err_hold got err=%b data=%h rv_n=%0d ret=%0d exp err=1 data=%h rv_n=6 ret=9", ob_err, ob_rdata, ob_rv_n, ob_ret, prd);
        end
        checks++;
        if (ob_viol !== 0) begin
            errors++;
            $display("FAIL err_no_accept got viol=%0d exp 0", ob_viol);
        end
        // The held second command is accepted on the very next edge
        do_xfer(1'b1, ~a, 32'hFFFF_FFFF, 1, 0, $urandom, 1'b0, 1'b0);
        checks++;
        if (ob_psel_first !== 1 || ob_rv_first !== 4 || ob_err !== 1'b0 || ob_viol !== 0) begin
            errors++;
            $display("FAIL b2b got psel=%0d rv=%0d err=%b viol=%0d exp 1/4/0/0", ob_psel_first, ob_rv_first, ob_err, ob_viol);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            logic        w    = 1'($urandom);
            logic [31:0] a    = $urandom;
            logic [31:0] d    = $urandom;
            logic [31:0] prd  = $urandom;
            logic        err  = 1'($urandom);
            int          wt   = $urandom_range(0, 4);
            int          rd   = $urandom_range(0, 3);
            do_xfer(w, a, d, wt, rd, prd, err, 1'b0);
            checks++;
            if (ob_psel_n !== 2 + wt || ob_pen_n !== 1 + wt || ob_rv_first !== 3 + wt ||
                ob_rv_n !== rd + 1 || ob_ret !== 4 + wt + rd) begin
                errors++;
                $display("FAIL rand%0d_timing got psel=%0d pen=%0d rv=%0d rvn=%0d ret=%0d wt=%0d rd=%0d",
                         i, ob_psel_n, ob_pen_n, ob_rv_first, ob_rv_n, ob_ret, wt, rd);
            end
            checks++;
            if (ob_rdata !== (w ? 32'h0 : prd) || ob_err !== err || ob_viol !== 0) begin
                errors++;
                $display("FAIL rand%0d_resp got %h err=%b viol=%0d exp %h err=%b viol=0",
                         i, ob_rdata, ob_err, ob_viol, w ? 32'h0 : prd, err);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = $urandom; cmd_wdata = $urandom;
        PREADY = 1'b0;
        for (int c = 0; c < 10 && seen < 2; c++) begin
            @(posedge PCLK); #1;
            cmd_valid = 1'b0;
            if (PSEL && PENABLE) seen++;
        end
        checks++;
        if (seen !== 2) begin
            errors++;
            $display("FAIL midrst_access got %0d access cycles exp 2", seen);
        end
        #2 PRESETn = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, rsp_valid} !== 3'b0 || PADDR !== 32'h0 || PWDATA !== 32'h0) begin
            errors++;
            $display("FAIL midrst_async got ctl=%b addr=%h exp ctl=000 addr=0", {PSEL, PENABLE, rsp_valid}, PADDR);
        end
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release got rdy=%b busy=%b exp 1/0", cmd_ready, busy);
        end
        do_xfer(1'b0, 32'h10, 32'h0, 0, 0, 32'h0020_0020, 1'b0, 1'b0);
        checks++;
        if (ob_rdata !== 32'h0020_0020 || ob_ret !== 4 || ob_viol !== 0) begin
            errors++;
            $display("FAIL midrst_next got %h ret=%0d viol=%0d exp 00200020 ret=4 viol=0", ob_rdata, ob_ret, ob_viol);
        end
    endtask

    task automatic test_stuck();
        int          rvf = -1;
        logic        e   = 1'bx;
        logic [31:0] r   = 'x;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = $urandom;
        PREADY = 1'b0; PRDATA = $urandom; rsp_ready = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge PCLK); #1;
            if (c == 1) cmd_valid = 1'b0;
            if (rsp_valid && rvf < 0) begin
                rvf = c; e = rsp_error; r = rsp_rdata;
            end
        end
`ifdef APB_TIMEOUT_EN
        checks++;
        if (rvf !== 3 + TMO || e !== 1'b1 || r !== 32'h0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout got rv=%0d err=%b data=%h rdy=%b exp rv=%0d err=1 data=0 rdy=1", rvf, e, r, cmd_ready, 3 + TMO);
        end
`else
        checks++;
        if (rvf !== -1 || !(PSEL && PENABLE) || busy !== 1'b1) begin
            errors++;
            $display("FAIL stuck_wait got rv=%0d psel=%b pen=%b exp rv=-1 psel=1 pen=1", rvf, PSEL, PENABLE);
        end
        PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hCAFE_0001;
        rvf = -1;
        for (int c = 1; c <= 10 && !cmd_ready; c++) begin
            @(posedge PCLK); #1;
            PREADY = 1'b0;
            if (rsp_valid && rvf < 0) begin
                rvf = c; r = rsp_rdata;
            end
        end
        checks++;
        if (rvf !== 1 || r !== 32'hCAFE_0001 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL stuck_release got rv=%0d data=%h rdy=%b exp rv=1 data=cafe0001 rdy=1", rvf, r, cmd_ready);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_read_regs();
        test_write_waits();
        test_error_back_to_back();
        test_random();
        test_reset_mid();
        test_stuck();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
